instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/decode control stage sitting directly upstream of the register-file + ALU datapath.
- Holds a small loadable instruction memory and a program counter.
- Steps through R-type instructions and drives the datapath control lines: RegWrite, Addr_op1, Addr_op2, Addr_Destino and Operacion.
- One instruction completes every 3 cycles; the block stops on a HALT opcode or at the end of memory.

Parameters:
- PC_WIDTH, 6, program counter width; memory depth = 2**PC_WIDTH words.
- INSTR_WIDTH, 32, instruction word width (fixed format below; must be 32).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or HALT.
- prog_we  in  1  instruction memory write enable.
- prog_addr  in  PC_WIDTH  instruction memory write address.
- prog_data  in  INSTR_WIDTH  instruction word to write.
- RegWrite  out  1  datapath write enable; one-cycle pulse in EXEC.
- Addr_op1  out  5  rs field.
- Addr_op2  out  5  rt field.
- Addr_Destino  out  5  rd field.
- Operacion  out  3  ALU operation code.
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in FETCH/DECODE/EXEC.
- done  out  1  high while in HALT.
- err  out  1  sticky: unknown funct or unknown opcode seen since start.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset value of every output is 0. Reset also sets state IDLE and PC=0. Memory contents are not cleared.
- Reset mid-execution aborts the instruction in progress; no RegWrite pulse is issued in that cycle.
- Instruction format: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt (ignored), [5:0] funct.
- Opcode 6'h00 = R-type; 6'h3F = HALT; any other opcode = NOP with err set.
- funct to Operacion mapping:
  - 6'h24 AND = 3'b000
  - 6'h25 OR = 3'b001
  - 6'h20 ADD = 3'b010
  - 6'h22 SUB = 3'b110
  - 6'h2A SLT = 3'b111
  - other funct: Operacion=3'b000, no write, err set.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: start goes to FETCH, with PC<=0 and err<=0.
  - FETCH: synchronous read IR<=mem[pc]; next state DECODE.
  - DECODE: register Addr_op1/Addr_op2/Addr_Destino/Operacion from IR.
    - HALT opcode: go to HALT; PC is not incremented.
    - Otherwise: go to EXEC.
  - EXEC: RegWrite=1 for exactly this cycle, only if R-type, funct is known and rd!=0. Address and operation outputs are stable from DECODE through EXEC and are held afterwards until the next DECODE.
    - If pc==2**PC_WIDTH-1: go to HALT, pc unchanged (no wrap).
    - Else: pc<=pc+1 and go to FETCH.
  - HALT: done=1; start restarts as from IDLE (PC<=0, err<=0).
- Latency:
  - start high in cycle N gives FETCH at N+1, DECODE at N+2, first RegWrite pulse at N+3.
  - Subsequent instructions issue every 3 cycles.
- prog_we is honoured only in IDLE or HALT; it is ignored while busy.
- If prog_we and start occur in the same cycle, the write is performed and start is also accepted. The first fetch sees the new word if prog_addr==0.
- start while busy is ignored.
- rd==0 suppresses RegWrite but is not an error.

Test Plan:
- Load mem[0]=0x00222820, mem[1]=0x00613022, mem[2]=0x00A63824, mem[3]=0xFC000000; pulse start.
  - Expect RegWrite pulses 3 cycles apart with (1,2,5,010), (3,1,6,110), (5,6,7,000).
  - Then done=1 with pc=3, err=0.
- Reset asserted during the DECODE of mem[1] → the next cycle shows all outputs 0 and state IDLE, with no RegWrite pulse. A following start re-executes from PC=0.
- mem[0]=0x0022003F (unknown funct), mem[1]=0xFC000000 → no RegWrite pulse, err=1, done=1. A new start clears err.
- mem[0]=0x00220020 (rd=0 ADD) → RegWrite stays 0, err stays 0, and Operacion=010 is observable.
- Fill all 64 words with 0x00222820 (no HALT) → 64 RegWrite pulses, then done=1 with pc=63 and no wrap to 0.
- Assert prog_we with prog_addr=0 while busy → memory unchanged. A re-run after HALT shows the original instruction.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode control stage for the register-file + ALU datapath.
// Holds a loadable instruction memory and a PC, and steps through R-type
// instructions at one instruction per three cycles (FETCH, DECODE, EXEC).
// Execution stops on a HALT opcode or after the last memory word.
module instr_sequencer #(
    parameter int PC_WIDTH    = 6,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   RegWrite,
    output logic [4:0]             Addr_op1,
    output logic [4:0]             Addr_op2,
    output logic [4:0]             Addr_Destino,
    output logic [2:0]             Operacion,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_LAST   = '1;
    localparam logic [5:0]          OP_RTYPE  = 6'h00;
    localparam logic [5:0]          OP_HALT   = 6'h3F;

    logic [INSTR_WIDTH-1:0] mem_q [2**PC_WIDTH];
    logic [INSTR_WIDTH-1:0] ir_q;
    state_t                 state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   regwrite_q;
    logic [4:0]             rs_q;
    logic [4:0]             rt_q;
    logic [4:0]             rd_q;
    logic [2:0]             oper_q;
    logic                   err_q;

    // Decoded view of the instruction register, consumed in DECODE
    logic [2:0] oper_d;
    logic       funct_ok_d;
    logic       is_rtype_d;
    logic       is_halt_d;
    logic       write_d;
    logic       bad_d;

    // The shamt field has no meaning for this datapath.
    logic       unused_shamt;
    assign unused_shamt = ^ir_q[10:6];

    // Programming port: writes land only while the sequencer is not running
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_HALT)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Instruction decode: opcode class, funct-to-ALU mapping, write qualification
    always_comb begin
        is_rtype_d = (ir_q[31:26] == OP_RTYPE);
        is_halt_d  = (ir_q[31:26] == OP_HALT);
        oper_d     = 3'b000;
        funct_ok_d = 1'b1;
        case (ir_q[5:0])
            6'h24:   oper_d = 3'b000;
            6'h25:   oper_d = 3'b001;
            6'h20:   oper_d = 3'b010;
            6'h22:   oper_d = 3'b110;
            6'h2A:   oper_d = 3'b111;
            default: funct_ok_d = 1'b0;
        endcase
        if (!is_rtype_d) begin
            oper_d = 3'b000;
        end
        write_d = is_rtype_d && funct_ok_d && (ir_q[15:11] != 5'd0);
        bad_d   = (is_rtype_d && !funct_ok_d) || (!is_rtype_d && !is_halt_d);
    end

    // Sequencer FSM with registered control outputs; RegWrite defaults low each cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            regwrite_q <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            oper_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_q    <= mem_q[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    rs_q   <= ir_q[25:21];
                    rt_q   <= ir_q[20:16];
                    rd_q   <= ir_q[15:11];
                    oper_q <= oper_d;
                    err_q  <= err_q | bad_d;
                    if (is_halt_d) begin
                        state_q <= S_HALT;
                    end else begin
                        regwrite_q <= write_d;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (pc_q == PC_LAST) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RegWrite     = regwrite_q;
    assign Addr_op1     = rs_q;
    assign Addr_op2     = rt_q;
    assign Addr_Destino = rd_q;
    assign Operacion    = oper_q;
    assign pc           = pc_q;
    assign err          = err_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign done         = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed scenarios plus randomized programs,
// checked against a program-level reference model of the instruction stream.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        RegWrite;
    logic [4:0]  Addr_op1;
    logic [4:0]  Addr_op2;
    logic [4:0]  Addr_Destino;
    logic [2:0]  Operacion;
    logic [5:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] HALT_W = 32'hFC000000;

    instr_sequencer #(.PC_WIDTH(6), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .RegWrite(RegWrite), .Addr_op1(Addr_op1), .Addr_op2(Addr_op2),
        .Addr_Destino(Addr_Destino), .Operacion(Operacion),
        .pc(pc), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state: bench copy of the program and expected outcome
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [2:0] op;
        int         k;
    } ev_t;

    logic [31:0] mem_m [64];
    ev_t         exp_q [$];
    int          exp_pc;
    bit          exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] w);
        prog_we   = 1'b1;
        prog_addr = 6'(a);
        prog_data = w;
        mem_m[a]  = w;
        tick();
        prog_we   = 1'b0;
    endtask

    // Walks the program in address order; instruction at address p writes
    // (if at all) in the EXEC cycle 3+3p samples after the start edge.
    function automatic void model();
        logic [31:0] w;
        logic [2:0]  op;
        bit          known;
        ev_t         e;
        exp_q.delete();
        exp_err = 0;
        exp_pc  = 63;
        for (int p = 0; p < 64; p++) begin
            w = mem_m[p];
            if (w[31:26] == 6'h3F) begin
                exp_pc = p;
                return;
            end
            if (w[31:26] != 6'h00) begin
                exp_err = 1;
            end else begin
                known = 1;
                op    = 3'b000;
                case (w[5:0])
                    6'h24: op = 3'b000;
                    6'h25: op = 3'b001;
                    6'h20: op = 3'b010;
                    6'h22: op = 3'b110;
                    6'h2A: op = 3'b111;
                    default: known = 0;
                endcase
                if (!known) exp_err = 1;
                else if (w[15:11] != 0) begin
                    e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
                    e.op = op; e.k = 3 + 3 * p;
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic run_prog(input string name, input bit wr0, input logic [31:0] w0);
        int  k;
        int  got;
        bit  fin;
        ev_t e;
        if (wr0) mem_m[0] = w0;
        model();
        start     = 1'b1;
        prog_we   = wr0;
        prog_addr = '0;
        prog_data = w0;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        k   = 1;
        got = 0;
        fin = 0;
        while (k <= 220) begin
            if (RegWrite === 1'b1) begin
                n_cmp++;
                if (got < exp_q.size()) begin
                    e = exp_q[got];
                    if ({Addr_op1, Addr_op2, Addr_Destino, Operacion} !== {e.rs, e.rt, e.rd, e.op} || k != e.k) begin
                        n_bad++;
                        $display("FAIL %s pulse%0d: got rs=%0d rt=%0d rd=%0d op=%b at k=%0d, want rs=%0d rt=%0d rd=%0d op=%b at k=%0d",
                                 name, got, Addr_op1, Addr_op2, Addr_Destino, Operacion, k, e.rs, e.rt, e.rd, e.op, e.k);
                    end
                end else begin
                    n_bad++;
                    $display("FAIL %s extra_pulse: got pulse #%0d at k=%0d, want only %0d pulses", name, got, k, exp_q.size());
                end
                got++;
            end
            if (done === 1'b1) begin
                fin = 1;
                break;
            end
            tick();
            k++;
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s timeout: done never rose within 220 cycles", name);
        end
        n_cmp++;
        if (got != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s pulse_count: got %0d, want %0d", name, got, exp_q.size());
        end
        n_cmp++;
        if ({pc, err, busy} !== {6'(exp_pc), exp_err, 1'b0}) begin
            n_bad++;
            $display("FAIL %s final: got pc=%0d err=%b busy=%b, want pc=%0d err=%b busy=0", name, pc, err, busy, exp_pc, exp_err);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 220) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s timeout: done=%b after %0d cycles, want 1", name, done, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({RegWrite, Addr_op1, Addr_op2, Addr_Destino, Operacion, pc, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got RegWrite=%b rs=%0d rt=%0d rd=%0d op=%b pc=%0d busy=%b done=%b err=%b, want all 0",
                     RegWrite, Addr_op1, Addr_op2, Addr_Destino, Operacion, pc, busy, done, err);
        end
        reset = 1'b0;
        for (int a = 0; a < 64; a++) load(a, HALT_W);
    endtask

    task automatic test_plan();
        load(0, 32'h00222820);
        load(1, 32'h00613022);
        load(2, 32'h00A63824);
        load(3, HALT_W);
        run_prog("plan", 0, '0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({RegWrite, Addr_op1, Addr_op2, Addr_Destino, Operacion, pc, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got RegWrite=%b rs=%0d rt=%0d rd=%0d op=%b pc=%0d busy=%b done=%b err=%b, want all 0",
                     RegWrite, Addr_op1, Addr_op2, Addr_Destino, Operacion, pc, busy, done, err);
        end
        tick();
        n_cmp++;
        if ({RegWrite, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got RegWrite=%b busy=%b, want 0 0", RegWrite, busy);
        end
        run_prog("rerun_after_reset", 0, '0);
    endtask

    task automatic test_bad_funct();
        load(0, 32'h0022003F);
        load(1, HALT_W);
        run_prog("bad_funct", 0, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({err, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL err_clear_on_start: got err=%b busy=%b, want err=0 busy=1", err, busy);
        end
        wait_done("bad_funct_rerun");
    endtask

    task automatic test_rd_zero();
        load(0, 32'h00220020);
        load(1, HALT_W);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({RegWrite, Operacion, Addr_Destino, err} !== {1'b0, 3'b010, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL rd_zero_exec: got RegWrite=%b op=%b rd=%0d err=%b, want 0 010 0 0", RegWrite, Operacion, Addr_Destino, err);
        end
        wait_done("rd_zero");
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_zero_err: got err=%b, want 0", err);
        end
    endtask

    task automatic test_full_mem();
        for (int a = 0; a < 64; a++) load(a, 32'h00222820);
        run_prog("full_mem", 0, '0);
        tick();
        tick();
        n_cmp++;
        if ({pc, done} !== {6'd63, 1'b1}) begin
            n_bad++;
            $display("FAIL full_mem_nowrap: got pc=%0d done=%b, want 63 1", pc, done);
        end
    endtask

    task automatic test_prog_while_busy();
        load(0, 32'h00222820);
        load(1, HALT_W);
        start = 1'b1;
        tick();
        start     = 1'b0;
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 32'h00A63824;
        tick();
        tick();
        tick();
        prog_we = 1'b0;
        wait_done("busy_write_run");
        run_prog("rerun_after_busy_write", 0, '0);
        run_prog("write_with_start", 1, 32'h00613022);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0]  f;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 99);
        if (r < 80) w[31:26] = 6'h00;
        else if (r < 84) w[31:26] = 6'h3F;
        else w[31:26] = 6'($urandom_range(1, 62));
        r = $urandom_range(0, 5);
        case (r)
            0: f = 6'h24;
            1: f = 6'h25;
            2: f = 6'h20;
            3: f = 6'h22;
            4: f = 6'h2A;
            default: f = 6'($urandom);
        endcase
        w[5:0] = f;
        if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
        return w;
    endfunction

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < 64; a++) load(a, rand_word());
            run_prog($sformatf("random%0d", it), 0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_reset_mid();
        test_bad_funct();
        test_rd_zero();
        test_full_mem();
        test_prog_while_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
